rtc_mtimer: RTL

Memory-mapped machine timer (RISC-V mtime/mtimecmp) on the CPU data bus. It replaces the free-running time value read at 0x80006000 and drives the machine-timer interrupt line IRQ[7] into PUCRS_RV. The block decodes CPU data reads and writes in its 32-byte window and returns read data combinationally for the bus read mux. It keeps a prescaled 64-bit counter and a registered compare interrupt.

---
 rtl/my_pkg.sv | 25 ++
 rtl/rtc_mtimer_tick_gen.sv | 36 +++
 rtl/rtc_mtimer.sv | 97 +++++++++
 3 files changed

// File: rtl/my_pkg.sv
// Shared MMIO definitions: register offsets within the timer window and the
// byte-merge helper used by memory-mapped peripherals.
package my_pkg;

    localparam logic [4:0] MTIME_LO_OFF    = 5'h00;
    localparam logic [4:0] MTIME_HI_OFF    = 5'h04;
    localparam logic [4:0] MTIMECMP_LO_OFF = 5'h08;
    localparam logic [4:0] MTIMECMP_HI_OFF = 5'h0C;
    localparam logic [4:0] CTRL_OFF        = 5'h10;
    localparam logic [4:0] MTIME_SNAP_OFF  = 5'h14;

    localparam int unsigned CTRL_EN_BIT = 0;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/rtc_mtimer_tick_gen.sv
// Prescaler: pulses tick once every PRESCALE enabled cycles. The count holds
// while disabled and restarts from zero when enable returns.
module tick_gen #(
    parameter int unsigned PRESCALE = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] cnt_q, cnt_d, cnt_eff;
    logic        en_prev_q, en_prev_d;

    always_comb begin
        en_prev_d = en;
        // First enabled cycle after a pause counts as position zero.
        cnt_eff   = en_prev_q ? cnt_q : '0;
        tick      = en && (cnt_eff == LAST);
        cnt_d     = cnt_q;
        if (en) cnt_d = tick ? '0 : cnt_eff + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            en_prev_q <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            en_prev_q <= en_prev_d;
        end
    end

endmodule

// File: rtl/rtc_mtimer.sv
// RISC-V style machine timer: prescaled 64-bit mtime, mtimecmp, enable,
// high-word snapshot and registered compare interrupt on the CPU data bus.
module rtc_mtimer
    import my_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_6000,
    parameter int unsigned PRESCALE  = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic [31:0] read_address,
    input  logic [3:0]  write,
    input  logic [31:0] write_address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        hit,
    output logic        mti
);

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] cmp_q, cmp_d;
    logic        en_q, en_d;
    logic [31:0] snap_q, snap_d;
    logic        mti_q, mti_d;
    logic        tick;
    logic        wr_hit;
    logic [4:0]  wr_off, rd_off;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{read_address[1:0], write_address[1:0]};

    assign wr_hit = (|write) && (write_address[31:5] == BASE_ADDR[31:5]);
    assign wr_off = {write_address[4:2], 2'b00};
    assign rd_off = {read_address[4:2], 2'b00};
    assign hit    = read && (read_address[31:5] == BASE_ADDR[31:5]);
    assign mti    = mti_q;

    tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (en_q),
        .tick  (tick)
    );

    always_comb begin
        data_out = '0;
        if (hit) begin
            case (rd_off)
                MTIME_LO_OFF:    data_out = mtime_q[31:0];
                MTIME_HI_OFF:    data_out = mtime_q[63:32];
                MTIMECMP_LO_OFF: data_out = cmp_q[31:0];
                MTIMECMP_HI_OFF: data_out = cmp_q[63:32];
                CTRL_OFF:        data_out = {31'b0, en_q};
                MTIME_SNAP_OFF:  data_out = snap_q;
                default:         data_out = '0;
            endcase
        end
    end

    always_comb begin
        mtime_d = mtime_q + {63'b0, tick};
        cmp_d   = cmp_q;
        en_d    = en_q;
        snap_d  = snap_q;
        mti_d   = (mtime_q >= cmp_q);
        // A bus write to either mtime half overrides the tick increment.
        if (wr_hit) begin
            case (wr_off)
                MTIME_LO_OFF:    mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], data_in, write)};
                MTIME_HI_OFF:    mtime_d = {merge_bytes(mtime_q[63:32], data_in, write), mtime_q[31:0]};
                MTIMECMP_LO_OFF: cmp_d   = {cmp_q[63:32], merge_bytes(cmp_q[31:0], data_in, write)};
                MTIMECMP_HI_OFF: cmp_d   = {merge_bytes(cmp_q[63:32], data_in, write), cmp_q[31:0]};
                CTRL_OFF:        if (write[0]) en_d = data_in[CTRL_EN_BIT];
                default:         ;
            endcase
        end
        if (hit && (rd_off == MTIME_LO_OFF)) snap_d = mtime_q[63:32];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mtime_q <= '0;
            cmp_q   <= '1;
            en_q    <= 1'b1;
            snap_q  <= '0;
            mti_q   <= 1'b0;
        end else begin
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            en_q    <= en_d;
            snap_q  <= snap_d;
            mti_q   <= mti_d;
        end
    end

endmodule
